game_timer: RTL

- Writer side of the 5-bit elapsed-seconds interface consumed by the on-screen countdown digits (which render GAME_SECONDS minus elapsed_time).
- Divides the system clock into 1 s ticks and counts elapsed game seconds from 0 to GAME_SECONDS.
- Supports start, pause and abort, and signals end of game to the game-control FSM and the score logic.

---
 rtl/reflex_pkg.sv | 19 +
 rtl/sec_prescaler.sv | 46 ++++
 rtl/game_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reflex_pkg.sv
// Shared definitions for the game timer slice.
//   timer_state_e    : timer FSM states
//   GAME_SECONDS_DEF : default game length in seconds
//   CLK_HZ           : system clock frequency, default prescaler divide
//   TIME_W           : width of the elapsed/remaining seconds fields
package reflex_pkg;

  localparam int unsigned GAME_SECONDS_DEF = 30;
  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned TIME_W           = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } timer_state_e;

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk_i down to one tick per game second.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : count enable (timer in RUN)
//   clr_i         : synchronous clear, wins over en_i
//   tick_o        : combinational, high on the cycle the counter wraps
module sec_prescaler
  import reflex_pkg::*;
#(
  parameter int unsigned TICK_DIV = CLK_HZ
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("sec_prescaler: TICK_DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Game timer: counts elapsed seconds 0..GAME_SECONDS with start/pause/abort.
//   clk_i, rst_ni      : clock, async active-low reset
//   start_i            : pulse, begins a game from IDLE or DONE
//   pause_i            : level, holds counting while high
//   abort_i            : pulse, returns to IDLE from any state
//   elapsed_time_o     : seconds elapsed in the current game
//   remaining_time_o   : GAME_SECONDS - elapsed_time_o
//   sec_tick_o         : one-cycle pulse per elapsed increment
//   running_o, done_o  : state is RUN / DONE
//   time_up_o          : one-cycle pulse when elapsed reaches GAME_SECONDS
// All outputs are registered from next-state values.
module game_timer
  import reflex_pkg::*;
#(
  parameter int unsigned TICK_DIV     = CLK_HZ,
  parameter int unsigned GAME_SECONDS = GAME_SECONDS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              abort_i,
  output logic [TIME_W-1:0] elapsed_time_o,
  output logic [TIME_W-1:0] remaining_time_o,
  output logic              sec_tick_o,
  output logic              running_o,
  output logic              time_up_o,
  output logic              done_o
);

  if (GAME_SECONDS < 1 || GAME_SECONDS > 31) begin : g_bad_seconds
    $error("game_timer: GAME_SECONDS must be in 1..31");
  end

  localparam logic [TIME_W-1:0] GS_FULL = TIME_W'(GAME_SECONDS);
  localparam logic [TIME_W-1:0] GS_LAST = TIME_W'(GAME_SECONDS - 1);

  timer_state_e      state_q, state_d;
  logic [TIME_W-1:0] elapsed_q, elapsed_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  logic              sec_tick_q, sec_tick_d;
  logic              time_up_q, time_up_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              tick;
  logic              presc_clr;

  sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == ST_RUN),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    sec_tick_d = 1'b0;
    time_up_d  = 1'b0;
    presc_clr  = 1'b0;

    if (abort_i) begin
      // Abort outranks a coincident tick: the increment is dropped.
      state_d   = ST_IDLE;
      elapsed_d = '0;
      presc_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_d   = pause_i ? ST_PAUSED : ST_RUN;
            elapsed_d = '0;
            presc_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            elapsed_d  = elapsed_q + 1'b1;
            sec_tick_d = 1'b1;
            if (elapsed_q == GS_LAST) begin
              state_d   = ST_DONE;
              time_up_d = 1'b1;
            end else if (pause_i) begin
              state_d = ST_PAUSED;
            end
          end else if (pause_i) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          // Prescaler is disabled here, so the partial second is kept.
          if (!pause_i) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    remaining_d = GS_FULL - elapsed_d;
    running_d   = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      elapsed_q   <= '0;
      remaining_q <= GS_FULL;
      sec_tick_q  <= 1'b0;
      time_up_q   <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      remaining_q <= remaining_d;
      sec_tick_q  <= sec_tick_d;
      time_up_q   <= time_up_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign elapsed_time_o   = elapsed_q;
  assign remaining_time_o = remaining_q;
  assign sec_tick_o       = sec_tick_q;
  assign time_up_o        = time_up_q;
  assign running_o        = running_q;
  assign done_o           = done_q;

endmodule
